param_seq_multiplier: RTL

PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

---
 rtl/param_seq_mul_pkg.sv | 17 +
 rtl/param_seq_mul_core.sv | 98 +++++++++
 rtl/param_seq_multiplier.sv | 119 +++++++++++
 3 files changed

// File: rtl/param_seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// param_seq_mul_pkg
// Shared definitions for the sequential shift-add multiplier:
//   DEFAULT_WIDTH - default operand width in bits
//   state_t       - control FSM states (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package param_seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/param_seq_mul_core.sv
// -----------------------------------------------------------------------------
// param_seq_mul_core
// Shift-add datapath: operand magnitude capture, one add/shift per step,
// and the final sign fix-up into the product register.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_start           capture operands and mode (accept edge)
//   i_a, i_b          raw multiplicand / multiplier
//   i_signed_mode     1 = two's-complement operands
//   i_step            perform one shift-add step this edge
//   i_last            this step is the final one; register the product
//   i_bypass_zero     on i_start, load product = 0 directly
//   o_zero_operand    either incoming operand magnitude is zero
//   o_product         registered 2*WIDTH-bit result
// -----------------------------------------------------------------------------
module param_seq_mul_core
  import param_seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed_mode,
  input  logic               i_step,
  input  logic               i_last,
  input  logic               i_bypass_zero,
  output logic               o_zero_operand,
  output logic [2*WIDTH-1:0] o_product
);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_mplr_next;
  logic [2*WIDTH-1:0] w_result;
  logic [2*WIDTH-1:0] w_signed_result;

  // Magnitudes are kept unsigned in WIDTH bits: negating the most-negative
  // value wraps back to 2^(WIDTH-1), which is exactly its magnitude.
  always_comb begin
    w_mag_a = i_a;
    w_mag_b = i_b;
    w_neg   = 1'b0;
    if (i_signed_mode) begin
      if (i_a[WIDTH-1]) w_mag_a = -i_a;
      if (i_b[WIDTH-1]) w_mag_b = -i_b;
      w_neg = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end
  end

  assign o_zero_operand = (w_mag_a == '0) || (w_mag_b == '0);

  // One step: conditional add into the upper half with a carry bit, then
  // shift {carry, acc, mplr} right by one. The bit leaving the adder's LSB
  // becomes the new top bit of the multiplier register (lower product half).
  always_comb begin
    w_sum           = {1'b0, r_acc} + ({(WIDTH+1){r_mplr[0]}} & {1'b0, r_mcand});
    w_acc_next      = w_sum[WIDTH:1];
    w_mplr_next     = {w_sum[0], r_mplr[WIDTH-1:1]};
    w_result        = {w_acc_next, w_mplr_next};
    w_signed_result = r_neg ? -w_result : w_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else if (i_start) begin
      r_mcand <= w_mag_a;
      r_mplr  <= w_mag_b;
      r_acc   <= '0;
      r_neg   <= w_neg;
      if (i_bypass_zero) r_product <= '0;
    end else if (i_step) begin
      r_acc  <= w_acc_next;
      r_mplr <= w_mplr_next;
      if (i_last) r_product <= w_signed_result;
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/param_seq_multiplier.sv
// -----------------------------------------------------------------------------
// param_seq_multiplier
// Sequential signed/unsigned WIDTH x WIDTH multiplier with valid/ready
// handshakes. One operation at a time; result after WIDTH cycles.
//
// Optional feature macro: PARAM_SEQ_MUL_ZERO_BYPASS_EN
//   defined   - a zero operand goes straight to DONE with product 0
//   undefined - zero operands take the normal WIDTH-step path
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      operand pair and mode present
//   in_ready      block accepts operands (state IDLE)
//   a, b          multiplicand, multiplier
//   signed_mode   1 = two's-complement, sampled with the operands
//   out_valid     product valid (state DONE)
//   out_ready     consumer takes product
//   product       2*WIDTH-bit result, held outside DONE
//   busy          state is not IDLE
// -----------------------------------------------------------------------------
module param_seq_multiplier
  import param_seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef PARAM_SEQ_MUL_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_last;
  logic w_step;
  logic w_zero_operand;
  logic w_bypass;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_step   = (r_state == CALC);
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));
  assign w_bypass = ZERO_BYPASS && w_zero_operand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = w_bypass ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Step counter: cleared on accept, advanced each CALC edge, and cleared
  // again after the final step so it never wraps for power-of-two WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

  param_seq_mul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_accept),
    .i_a            (a),
    .i_b            (b),
    .i_signed_mode  (signed_mode),
    .i_step         (w_step),
    .i_last         (w_last),
    .i_bypass_zero  (w_bypass),
    .o_zero_operand (w_zero_operand),
    .o_product      (product)
  );

endmodule
